jk_flipflop_bank: RTL



---
 rtl/jk_bank_pkg.sv | 24 ++
 rtl/jk_bank_edge_det.sv | 34 +++
 rtl/jk_flipflop_bank.sv | 64 ++++++
 3 files changed

// File: rtl/jk_bank_pkg.sv
// Shared constants, per-channel control bundle and next-state helpers for jk_flipflop_bank.
package jk_bank_pkg;

  localparam bit TRIG_FALL = 1'b0;
  localparam bit TRIG_RISE = 1'b1;

  typedef struct packed {
    logic j;
    logic k;      // true K, after any K-bar inversion
    logic clr_n;
    logic pre_n;
  } jk_ctl_t;

  // 00 hold, 10 set, 01 clear, 11 toggle
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (~q & j) | (q & ~k);
  endfunction

  // Level the trigger rests at between active edges
  function automatic logic idle_level(input logic edge_sel);
    return ~edge_sel;
  endfunction

endpackage

// File: rtl/jk_bank_edge_det.sv
// Single-bit trigger edge detector; with JK_BANK_TRIG_SYNC_EN defined the trigger
// first passes a 2-flop synchroniser. All history flops reset to the idle level.
module jk_bank_edge_det
  import jk_bank_pkg::*;
#(
  parameter bit EDGE = TRIG_FALL,
  parameter bit IDLE = idle_level(EDGE)
) (
  input  logic clk,
  input  logic clrn,
  input  logic trig,
  output logic hit
);

  logic lvl;
  logic trig_q;

`ifdef JK_BANK_TRIG_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) sync <= {2{IDLE}};
    else       sync <= {sync[0], trig};
  assign lvl = sync[1];
`else
  assign lvl = trig;
`endif

  always_ff @(posedge clk or negedge clrn)
    if (!clrn) trig_q <= IDLE;
    else       trig_q <= lvl;

  assign hit = (EDGE == TRIG_RISE) ? (~trig_q & lvl) : (trig_q & ~lvl);

endmodule

// File: rtl/jk_flipflop_bank.sv
// N-channel JK flip-flop bank clocked by sampled trigger edges on a single system clock.
// Optional 2-flop trigger synchroniser: define JK_BANK_TRIG_SYNC_EN.
module jk_flipflop_bank
  import jk_bank_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int TRIG_EDGE = 0,
  parameter int KBAR_MODE = 0
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [CHANNELS-1:0] j,
  input  logic [CHANNELS-1:0] k,
  input  logic [CHANNELS-1:0] trig,
  input  logic [CHANNELS-1:0] clr_n,
  input  logic [CHANNELS-1:0] pre_n,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] qn,
  output logic [CHANNELS-1:0] evt
);

  localparam bit EDGE = (TRIG_EDGE != 0);

  logic [CHANNELS-1:0] k_int;
  logic [CHANNELS-1:0] hit;

  assign k_int = (KBAR_MODE != 0) ? ~k : k;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    jk_ctl_t ctl;
    logic    q_r;
    logic    evt_r;

    assign ctl = '{j: j[i], k: k_int[i], clr_n: clr_n[i], pre_n: pre_n[i]};

    jk_bank_edge_det #(
      .EDGE (EDGE),
      .IDLE (idle_level(EDGE))
    ) u_det (
      .clk  (clk),
      .clrn (clrn),
      .trig (trig[i]),
      .hit  (hit[i])
    );

    // evt reports the accepted edge even when clear/preset wins over the JK update
    always_ff @(posedge clk or negedge clrn)
      if (!clrn) begin
        q_r   <= 1'b0;
        evt_r <= 1'b0;
      end else begin
        evt_r <= hit[i];
        if (!ctl.clr_n)      q_r <= 1'b0;
        else if (!ctl.pre_n) q_r <= 1'b1;
        else if (hit[i])     q_r <= jk_next(q_r, ctl.j, ctl.k);
      end

    assign q[i]   = q_r;
    assign evt[i] = evt_r;
  end

  assign qn = ~q;

endmodule
